// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin arbiter and auto-refresh scheduler for the SDRAM controller
module sdram_arbiter #(
    parameter int RFSH_PERIOD = 1950,
    parameter int DEBT_MAX    = 7
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        pa_req,
    input  logic        pa_we,
    input  logic [21:0] pa_addr,
    input  logic [15:0] pa_wdata,
    output logic        pa_ack,
    output logic [15:0] pa_rdata,
    input  logic        pb_req,
    input  logic        pb_we,
    input  logic [21:0] pb_addr,
    input  logic [15:0] pb_wdata,
    output logic        pb_ack,
    output logic [15:0] pb_rdata,
    output logic [21:0] ctl_addr,
    output logic [15:0] ctl_data_in,
    output logic        ctl_write_rq,
    output logic        ctl_read_rq,
    output logic        ctl_rfsh_rq,
    input  logic [15:0] ctl_data_out,
    input  logic        ctl_busy,
    output logic        rfsh_overflow
);
    localparam int            TW         = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(RFSH_PERIOD - 1);
    localparam logic [2:0]    DEBT_SAT   = 3'(DEBT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    debt_q, debt_d;
    logic          ovf_q, ovf_d;
    logic          tick;
    logic          rfsh_issue;
    logic          pick_b;

    logic          last_b_q;
    logic          gnt_b_q;
    logic          we_q;
    logic          is_rfsh_q;
    logic          pa_ack_q, pb_ack_q;
    logic [15:0]   pa_rdata_q, pb_rdata_q;
    logic [21:0]   ctl_addr_q;
    logic [15:0]   ctl_data_in_q;
    logic          write_rq_q, read_rq_q, rfsh_rq_q;

    assign tick       = (timer_q == TIMER_LAST);
    assign rfsh_issue = (state_q == IDLE) && !ctl_busy && (debt_q != 3'd0);
    // With both ports asking, B wins only when A was served last.
    assign pick_b     = pb_req && (!pa_req || !last_b_q);

    always_comb begin
        timer_d = tick ? '0 : timer_q + 1'b1;
        debt_d  = debt_q;
        ovf_d   = ovf_q;
        if (tick && !rfsh_issue) begin
            if (debt_q == DEBT_SAT) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + 3'd1;
            end
        end else if (!tick && rfsh_issue) begin
            debt_d = debt_q - 3'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            timer_q <= '0;
            debt_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            debt_q  <= debt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q       <= IDLE;
            last_b_q      <= 1'b1;
            gnt_b_q       <= 1'b0;
            we_q          <= 1'b0;
            is_rfsh_q     <= 1'b0;
            pa_ack_q      <= 1'b0;
            pb_ack_q      <= 1'b0;
            pa_rdata_q    <= 16'h0000;
            pb_rdata_q    <= 16'h0000;
            ctl_addr_q    <= 22'h000000;
            ctl_data_in_q <= 16'h0000;
            write_rq_q    <= 1'b0;
            read_rq_q     <= 1'b0;
            rfsh_rq_q     <= 1'b0;
        end else begin
            write_rq_q <= 1'b0;
            read_rq_q  <= 1'b0;
            rfsh_rq_q  <= 1'b0;
            pa_ack_q   <= 1'b0;
            pb_ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ctl_busy) begin
                        if (debt_q != 3'd0) begin
                            is_rfsh_q <= 1'b1;
                            rfsh_rq_q <= 1'b1;
                            state_q   <= ISSUE;
                        end else if (pa_req || pb_req) begin
                            is_rfsh_q     <= 1'b0;
                            gnt_b_q       <= pick_b;
                            last_b_q      <= pick_b;
                            we_q          <= pick_b ? pb_we : pa_we;
                            ctl_addr_q    <= pick_b ? pb_addr : pa_addr;
                            ctl_data_in_q <= pick_b ? pb_wdata : pa_wdata;
                            write_rq_q    <= pick_b ? pb_we : pa_we;
                            read_rq_q     <= pick_b ? !pb_we : !pa_we;
                            state_q       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    if (ctl_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!ctl_busy) begin
                        if (is_rfsh_q) begin
                            state_q <= IDLE;
                        end else begin
                            if (!we_q && gnt_b_q) begin
                                pb_rdata_q <= ctl_data_out;
                            end
                            if (!we_q && !gnt_b_q) begin
                                pa_rdata_q <= ctl_data_out;
                            end
                            pa_ack_q <= !gnt_b_q;
                            pb_ack_q <= gnt_b_q;
                            state_q  <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pa_ack        = pa_ack_q;
    assign pb_ack        = pb_ack_q;
    assign pa_rdata      = pa_rdata_q;
    assign pb_rdata      = pb_rdata_q;
    assign ctl_addr      = ctl_addr_q;
    assign ctl_data_in   = ctl_data_in_q;
    assign ctl_write_rq  = write_rq_q;
    assign ctl_read_rq   = read_rq_q;
    assign ctl_rfsh_rq   = rfsh_rq_q;
    assign rfsh_overflow = ovf_q;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and refresh scheduler in front of the SDRAM controller. It shares the controller's single request interface between two client ports, A and B, using round-robin. It generates periodic auto-refresh requests from a free-running timer and tracks outstanding refreshes as a debt counter. It sits between the system logic and the controller's `sys_*` host interface, in the `sys_clk` domain.

## Interface
Parameters:
- `RFSH_PERIOD`, 1950: `sys_clk` cycles per refresh tick. 64 ms / 4096 rows at 128 MHz, with margin.
- `DEBT_MAX`, 7: saturation value of the refresh debt counter (3 bits).

Ports:
- `sys_clk` in 1: single clock; all logic runs on the rising edge.
- `sys_reset` in 1: reset, asynchronous and active-high.
- `pa_req` in 1: port A request (level, held until `pa_ack`).
- `pa_we` in 1: port A 1 = write, 0 = read.
- `pa_addr` in 22: port A word address.
- `pa_wdata` in 16: port A write data.
- `pa_ack` out 1: one-cycle completion pulse.
- `pa_rdata` out 16: port A read data.
- `pb_req`, `pb_we`, `pb_addr`, `pb_wdata`, `pb_ack`, `pb_rdata`: same as port A, for port B.
- `ctl_addr` out 22: to controller `sys_addr`.
- `ctl_data_in` out 16: to controller `sys_data_in`.
- `ctl_write_rq` out 1: to controller `sys_write_rq`.
- `ctl_read_rq` out 1: to controller `sys_read_rq`.
- `ctl_rfsh_rq` out 1: to controller `sys_rfsh_rq`.
- `ctl_data_out` in 16: from controller read data.
- `ctl_busy` in 1: from controller `sys_busy`.
- `rfsh_overflow` out 1: sticky; a tick arrived while debt = `DEBT_MAX`.

## Operation
- Controller contract: an `*_rq` pulse is sampled while `ctl_busy` = 0. The controller raises `ctl_busy` the next cycle and drops it when done. Read data is valid on `ctl_data_out` in the first cycle `ctl_busy` = 0 after the operation.
- Refresh timer: counts 0..`RFSH_PERIOD`-1 and wraps. The wrap is the tick, and it runs from reset regardless of FSM state.
- Refresh debt, 3 bits:
  - tick increments it;
  - issuing a refresh decrements it;
  - tick and issue in the same cycle leave it unchanged;
  - tick at `DEBT_MAX` keeps it at `DEBT_MAX` and sets `rfsh_overflow`.
- FSM states:
  - IDLE: wait for `ctl_busy` = 0. Then:
    - if debt > 0, select refresh and go to ISSUE;
    - otherwise, if any `p*_req` is high, grant a port and go to ISSUE;
    - otherwise stay in IDLE.
  - ISSUE: assert exactly one of `ctl_write_rq`, `ctl_read_rq`, `ctl_rfsh_rq` for one cycle, then go to WAIT_ACCEPT.
  - WAIT_ACCEPT: wait for `ctl_busy` = 1, then go to WAIT_DONE.
  - WAIT_DONE: on `ctl_busy` = 0:
    - for a port read, capture `ctl_data_out` into the granted port's `p*_rdata`;
    - for a port operation, go to RESPOND;
    - for a refresh, go to IDLE.
  - RESPOND: the granted `p*_ack` = 1 for this one cycle, then go to IDLE.
- Grant and latching:
  - Refresh always beats ports.
  - If both ports request, grant the one not granted last; the `last` bit resets to B, so A wins first.
  - A single requester is granted regardless of `last`.
  - `last` updates only on port grants.
  - At grant, latch `addr` and `wdata` into `ctl_addr` and `ctl_data_in`; they stay stable until the next grant.
  - Refresh grants leave `ctl_addr` and `ctl_data_in` unchanged.
- `p*_req` is evaluated only in IDLE. A request still high in the cycle after `ack` counts as a new transaction.
- `p*_rdata` holds its value until the next read on the same port. Writes do not change it.
- Reset, asynchronous, including mid-operation:
  - FSM returns to IDLE; timer, debt, `last` (= B) and `rfsh_overflow` are reinitialised.
  - All outputs go to 0.
  - No `ack` is issued for an aborted transaction.

## Timing
- Reset values: every output 0. `rfsh_overflow` 0, debt 0, timer 0.
- Port latency: with `req` seen in IDLE at cycle 0 (debt 0, `ctl_busy` 0):
  - `ctl_*_rq` = 1 at cycle 1;
  - if `ctl_busy` is high for cycles 2..k and low at k+1, `p*_ack` = 1 at cycle k+2;
  - for reads, `rdata` is valid from cycle k+2.
- Minimum spacing between consecutive issued requests is 3 cycles plus the busy duration.
- `ctl_busy` high after reset (controller init) holds the FSM in IDLE. Debt accumulates meanwhile and is drained first, one refresh per IDLE pass.
- Request outputs are registered: `*_rq` is never high for 2 consecutive cycles, and never two at once.

## Test plan
- Single read: port A reads 0x12345 while the controller model stays busy 6 cycles and returns 0xBEEF. Required response: one `ctl_read_rq` pulse with `ctl_addr` = 0x12345; `pa_ack` pulse 2 cycles after the busy fall; `pa_rdata` = 0xBEEF; `pb_ack` stays 0.
- Round-robin: `pa_req` and `pb_req` held high for 4 transactions each. Required response: grants alternate A, B, A, B, …; 8 acks total; each `ctl_addr` matches the granted port.
- Refresh priority: `RFSH_PERIOD` = 20; a tick coincides with a pending port A request. Required response: `ctl_rfsh_rq` issued before the port read; debt returns to 0.
- Debt saturation: `ctl_busy` held 1 for 9 × `RFSH_PERIOD`. Required response: debt = 7; `rfsh_overflow` = 1. On release, 7 back-to-back refresh pulses occur before any port grant.
- Reset mid-WAIT_DONE during a port B write. Required response: all outputs 0 immediately; no `pb_ack`. After release, the first grant with both ports requesting goes to A.
- Write: port B writes 0xA5A5 to 0x3FFFFF. Required response: `ctl_write_rq` pulse with `ctl_data_in` = 0xA5A5 and `ctl_addr` = 0x3FFFFF held through busy; `pb_rdata` unchanged.
